counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Command-driven controller for the 4-bit user-area counter on io_out[3:0].
//  Sequences counting through the states IDLE, RUN and DONE, with a programmable prescaler, a terminal limit and optional wrap.
//  Owns io_oeb: pins are tri-stated until the first START.
//  Accepts commands over a valid/ready handshake from the user-area command source.
// PARAMETERS
//  WIDTH      4  counter / io_out width
//  PRESC_W    8  prescaler reload width (cmd_data_i width)
// PORTS
//  wb_clk_i     in   1        system clock; everything is posedge
//  wb_rst_n     in   1        asynchronous reset, active-low
//  cmd_valid_i  in   1        command present
//  cmd_ready_o  out  1        command accepted when valid&ready
//  cmd_op_i     in   2        00 START, 01 STOP, 10 LOAD_LIMIT, 11 CLEAR
//  cmd_data_i   in   PRESC_W  START: prescale P; LOAD_LIMIT: [WIDTH-1:0]=limit, [4]=wrap_en
//  io_out       out  WIDTH    counter value
//  io_oeb       out  WIDTH    pad output-enable bar; all 1 = tri-state, all 0 = driving
//  busy_o       out  1        1 while the state is RUN
//  done_o       out  1        1-cycle pulse on terminal count without wrap
//  wrap_o       out  1        1-cycle pulse on terminal count with wrap
//  err_o        out  1        1-cycle pulse when START or LOAD_LIMIT arrives in RUN
// BEHAVIOUR
//  Reset (wb_rst_n=0, async):
//   - Outputs: io_out=0, io_oeb=all 1, cmd_ready_o=1, busy/done/wrap/err=0.
//   - Internal: state=IDLE, limit={WIDTH{1}}, wrap_en=0, presc_cnt=0, P=0.
//   - Outputs take reset values immediately (asynchronously), including mid-RUN.
//  cmd_ready_o is 1 in every state. Accept = cmd_valid_i & cmd_ready_o.
//  FSM IDLE/RUN/DONE; transitions on accept at cycle T take effect at T+1.
//  START (IDLE or DONE):
//   - Effects: io_out<=0, P<=cmd_data_i, presc_cnt<=P, io_oeb<=0.
//   - State: ->RUN. If limit==0 and wrap_en=0, ->DONE instead, with done_o at T+1.
//  START in RUN: dropped, no state change; err_o=1 at T+1.
//  STOP:
//   - RUN->IDLE. io_out holds its value; presc_cnt<=0.
//   - In IDLE or DONE: no effect.
//  LOAD_LIMIT:
//   - IDLE/DONE: limit and wrap_en updated at T+1; state unchanged.
//   - RUN: dropped; err_o=1 at T+1.
//  CLEAR: any state ->IDLE; io_out<=0, io_oeb<=all 1, presc_cnt<=0. limit and wrap_en are kept.
//  RUN tick:
//   - presc_cnt decrements each cycle. At 0 it reloads P and asserts an internal tick.
//   - Ticks therefore occur every P+1 cycles; the first tick is at T+1+P.
//  On tick:
//   - io_out != limit: io_out<=io_out+1, modulo 2^WIDTH.
//   - io_out == limit, wrap_en=1: io_out<=0; wrap_o pulses in the same cycle io_out shows 0.
//   - io_out == limit, wrap_en=0: ->DONE, io_out holds limit; done_o pulses in the first DONE cycle.
//  Terminal state: limit={WIDTH{1}} with wrap_en=1 wraps F->0 naturally, and wrap_o still pulses.
//  DONE: io_out holds; io_oeb stays 0; only START, CLEAR or LOAD_LIMIT act.
//  Simultaneous accepted STOP/CLEAR and terminal tick: the command wins; no done_o or wrap_o.
//  busy_o = (state==RUN), registered. done/wrap/err are never high more than 1 cycle.
// TESTING
//  1. Reset, then START P=0 with the default limit F, wrap_en=0.
//     -> io_oeb=0 next cycle; io_out 0,1..F one per cycle; done_o once at F; busy_o drops.
//  2. LOAD_LIMIT data=0x15 (limit 5, wrap_en=1), START P=2.
//     -> io_out steps every 3 cycles 0..5,0; wrap_o pulses with io_out=0; busy_o stays 1.
//  3. START P=3, STOP at io_out=2, then START.
//     -> STOP: io_out holds 2, busy_o=0. START: io_out=0 and counting resumes.
//  4. In RUN, issue START, then LOAD_LIMIT 0x07.
//     -> err_o pulses each time; limit, P and count unaffected.
//  5. Drive CLEAR in the exact cycle io_out reaches limit (wrap_en=0).
//     -> no done_o; io_out=0, io_oeb=F, state IDLE.
//  6. Assert wb_rst_n low mid-RUN, off-clock-edge.
//     -> outputs reset immediately; limit returns to F.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for the user-area counter.
// It accepts START/STOP/LOAD_LIMIT/CLEAR over a valid/ready handshake and runs
// an IDLE/RUN/DONE FSM. A programmable prescaler sets the counting rate, and a
// terminal limit with optional wrap bounds the count.
// The counter pads stay tri-stated until the first START.
module counter_sequencer #(
   parameter int WIDTH   = 4,
   parameter int PRESC_W = 8
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_n,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_op_i,
   input  logic [PRESC_W-1:0] cmd_data_i,
   output logic [WIDTH-1:0]   io_out,
   output logic [WIDTH-1:0]   io_oeb,
   output logic               busy_o,
   output logic               done_o,
   output logic               wrap_o,
   output logic               err_o
);

   // The wrap-enable flag sits just above the limit field in LOAD_LIMIT data.
   localparam int WRAP_BIT = WIDTH;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t               state_q,     state_d;
   logic [WIDTH-1:0]     io_out_q,    io_out_d;
   logic [WIDTH-1:0]     io_oeb_q,    io_oeb_d;
   logic [WIDTH-1:0]     limit_q,     limit_d;
   logic                 wrap_en_q,   wrap_en_d;
   logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
   logic [PRESC_W-1:0]   presc_q,     presc_d;
   logic                 busy_q,      busy_d;
   logic                 done_q,      done_d;
   logic                 wrap_q,      wrap_d;
   logic                 err_q,       err_d;

   logic                 accept;
   logic                 tick;
   logic                 at_limit;

   // The controller never back-pressures, so every valid command is taken.
   assign cmd_ready_o = 1'b1;
   assign accept      = cmd_valid_i & cmd_ready_o;

   // A prescaler tick fires in RUN whenever the down-counter has reached zero.
   assign tick     = (state_q == ST_RUN) && (presc_cnt_q == '0);
   assign at_limit = (io_out_q == limit_q);

   assign io_out = io_out_q;
   assign io_oeb = io_oeb_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
   assign wrap_o = wrap_q;
   assign err_o  = err_q;

   // Next-state decode: commands first, then the RUN prescaler and terminal count.
   always_comb begin
      state_d     = state_q;
      io_out_d    = io_out_q;
      io_oeb_d    = io_oeb_q;
      limit_d     = limit_q;
      wrap_en_d   = wrap_en_q;
      presc_cnt_d = presc_cnt_q;
      presc_d     = presc_q;
      done_d      = 1'b0;
      wrap_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               case (cmd_op_i)
                  OP_START: begin
                     io_out_d    = '0;
                     presc_d     = cmd_data_i;
                     presc_cnt_d = cmd_data_i;
                     io_oeb_d    = '0;
                     // A zero limit without wrap has nothing to count: finish at once.
                     if ((limit_q == '0) && !wrap_en_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end else begin
                        state_d = ST_RUN;
                     end
                  end
                  OP_LOAD: begin
                     limit_d   = cmd_data_i[WIDTH-1:0];
                     wrap_en_d = cmd_data_i[WRAP_BIT];
                  end
                  OP_CLEAR: begin
                     state_d     = ST_IDLE;
                     io_out_d    = '0;
                     io_oeb_d    = '1;
                     presc_cnt_d = '0;
                  end
                  default: begin
                     // STOP outside RUN has nothing to stop.
                  end
               endcase
            end
         end

         ST_RUN: begin
            if (accept && (cmd_op_i == OP_CLEAR)) begin
               // CLEAR beats a coincident terminal tick, so no done/wrap pulse.
               state_d     = ST_IDLE;
               io_out_d    = '0;
               io_oeb_d    = '1;
               presc_cnt_d = '0;
            end else if (accept && (cmd_op_i == OP_STOP)) begin
               // STOP freezes the visible count and keeps the pads driven.
               state_d     = ST_IDLE;
               presc_cnt_d = '0;
            end else begin
               // START/LOAD_LIMIT while running are dropped and flagged;
               // counting carries on untouched.
               if (accept) begin
                  err_d = 1'b1;
               end
               if (tick) begin
                  presc_cnt_d = presc_q;
                  if (!at_limit) begin
                     io_out_d = io_out_q + WIDTH'(1);
                  end else if (wrap_en_q) begin
                     io_out_d = '0;
                     wrap_d   = 1'b1;
                  end else begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  presc_cnt_d = presc_cnt_q - PRESC_W'(1);
               end
            end
         end

         default: begin
            // Unreachable encoding: recover to a quiet IDLE.
            state_d     = ST_IDLE;
            io_out_d    = '0;
            io_oeb_d    = '1;
            presc_cnt_d = '0;
         end
      endcase

      busy_d = (state_d == ST_RUN);
   end

   // FSM and all registered outputs, reset asynchronously to the quiet state.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state_q     <= ST_IDLE;
         io_out_q    <= '0;
         io_oeb_q    <= '1;
         limit_q     <= '1;
         wrap_en_q   <= 1'b0;
         presc_cnt_q <= '0;
         presc_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         io_out_q    <= io_out_d;
         io_oeb_q    <= io_oeb_d;
         limit_q     <= limit_d;
         wrap_en_q   <= wrap_en_d;
         presc_cnt_q <= presc_cnt_d;
         presc_q     <= presc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         wrap_q      <= wrap_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with hand-computed expectations.
module tb_counter_sequencer;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_STOP  = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic [3:0] io_out;
   logic [3:0] io_oeb;
   logic       busy, done, wrap, err;

   int n_cmp = 0;
   int n_bad = 0;

   counter_sequencer #(.WIDTH(4), .PRESC_W(8)) dut (
      .wb_clk_i    (clk),
      .wb_rst_n    (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_op_i    (cmd_op),
      .cmd_data_i  (cmd_data),
      .io_out      (io_out),
      .io_oeb      (io_oeb),
      .busy_o      (busy),
      .done_o      (done),
      .wrap_o      (wrap),
      .err_o       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; sampling point is 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Present one command for exactly one accepting edge; returns at T+1.
   task automatic cmd(input logic [1:0] op, input logic [7:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      step();
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 8'h00;
      $display("cmd op=%0d data=0x%02h -> io_out=%0h oeb=%0h busy=%0b done=%0b wrap=%0b err=%0b",
               op, data, io_out, io_oeb, busy, done, wrap, err);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_cnt;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_data  = 8'h00;
      #12;
      // Reset state
      check("rst_io_out", 8'(io_out), 8'h0);
      check("rst_io_oeb", 8'(io_oeb), 8'hF);
      check("rst_ready",  8'(cmd_ready), 8'h1);
      check("rst_busy",   8'(busy), 8'h0);
      check("rst_pulses", {5'b0, done, wrap, err}, 8'h0);
      #5 rst_n = 1'b1;
      step();

      // 1: default limit F, no wrap, P=0 -> one step per cycle, done at F
      cmd(OP_START, 8'h00);
      check("t1_oeb", 8'(io_oeb), 8'h0);
      check("t1_out0", 8'(io_out), 8'h0);
      check("t1_busy", 8'(busy), 8'h1);
      done_cnt = 0;
      for (int v = 1; v <= 15; v++) begin
         step();
         check($sformatf("t1_out%0d", v), 8'(io_out), 8'(v));
         if (done) done_cnt++;
      end
      check("t1_busy_at_F", 8'(busy), 8'h1);
      step();
      check("t1_done", 8'(done), 8'h1);
      check("t1_hold_F", 8'(io_out), 8'hF);
      check("t1_busy_drop", 8'(busy), 8'h0);
      step();
      check("t1_done_1cyc", 8'(done), 8'h0);
      check("t1_no_early_done", 8'(done_cnt), 8'h0);

      // 2: limit 5 with wrap, P=2 -> step every 3 cycles, wrap to 0
      cmd(OP_LOAD, 8'h15);
      check("t2_load_busy", 8'(busy), 8'h0);
      cmd(OP_START, 8'h02);
      check("t2_out0", 8'(io_out), 8'h0);
      for (int v = 1; v <= 5; v++) begin
         steps(2);
         check($sformatf("t2_hold%0d", v - 1), 8'(io_out), 8'(v - 1));
         step();
         check($sformatf("t2_out%0d", v), 8'(io_out), 8'(v));
      end
      steps(2);
      check("t2_hold5", 8'(io_out), 8'h5);
      check("t2_no_wrap_yet", 8'(wrap), 8'h0);
      step();
      check("t2_wrap_out", 8'(io_out), 8'h0);
      check("t2_wrap", 8'(wrap), 8'h1);
      check("t2_busy", 8'(busy), 8'h1);
      step();
      check("t2_wrap_1cyc", 8'(wrap), 8'h0);
      cmd(OP_CLEAR, 8'h00);
      check("t2_clear_oeb", 8'(io_oeb), 8'hF);
      check("t2_clear_busy", 8'(busy), 8'h0);

      // 3: P=3, STOP at 2, restart
      cmd(OP_START, 8'h03);
      steps(7);
      check("t3_out1", 8'(io_out), 8'h1);
      step();
      check("t3_out2", 8'(io_out), 8'h2);
      cmd(OP_STOP, 8'h00);
      check("t3_stop_out", 8'(io_out), 8'h2);
      check("t3_stop_busy", 8'(busy), 8'h0);
      steps(5);
      check("t3_stop_hold", 8'(io_out), 8'h2);
      check("t3_stop_oeb", 8'(io_oeb), 8'h0);
      cmd(OP_START, 8'h03);
      check("t3_restart_out", 8'(io_out), 8'h0);
      check("t3_restart_busy", 8'(busy), 8'h1);
      steps(4);
      check("t3_resume", 8'(io_out), 8'h1);

      // 4: START and LOAD_LIMIT in RUN are rejected with err
      cmd(OP_START, 8'h00);
      check("t4_err_start", 8'(err), 8'h1);
      check("t4_count_kept", 8'(io_out), 8'h1);
      step();
      check("t4_err_1cyc", 8'(err), 8'h0);
      cmd(OP_LOAD, 8'h07);
      check("t4_err_load", 8'(err), 8'h1);
      step();
      check("t4_err_1cyc2", 8'(err), 8'h0);
      check("t4_out2", 8'(io_out), 8'h2);
      steps(4);
      check("t4_P_kept", 8'(io_out), 8'h3);
      steps(8);
      check("t4_out5", 8'(io_out), 8'h5);
      steps(4);
      check("t4_limit_kept", 8'(io_out), 8'h0);
      check("t4_wrap", 8'(wrap), 8'h1);

      // 5: CLEAR coincident with terminal tick wins
      cmd(OP_CLEAR, 8'h00);
      cmd(OP_LOAD, 8'h03);
      cmd(OP_START, 8'h00);
      steps(3);
      check("t5_at_limit", 8'(io_out), 8'h3);
      cmd(OP_CLEAR, 8'h00);
      check("t5_no_done", 8'(done), 8'h0);
      check("t5_out", 8'(io_out), 8'h0);
      check("t5_oeb", 8'(io_oeb), 8'hF);
      check("t5_busy", 8'(busy), 8'h0);
      step();
      check("t5_no_done_late", 8'(done), 8'h0);

      // 6: asynchronous reset mid-RUN, then default limit F is back
      cmd(OP_START, 8'h01);
      steps(3);
      check("t6_running", 8'(busy), 8'h1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_async_out", 8'(io_out), 8'h0);
      check("t6_async_oeb", 8'(io_oeb), 8'hF);
      check("t6_async_busy", 8'(busy), 8'h0);
      #3 rst_n = 1'b1;
      step();
      cmd(OP_START, 8'h00);
      steps(4);
      check("t6_past_old_limit", 8'(io_out), 8'h4);
      steps(11);
      check("t6_out_F", 8'(io_out), 8'hF);
      step();
      check("t6_done_at_F", 8'(done), 8'h1);

      // Boundary: limit 0 without wrap finishes straight from START
      cmd(OP_LOAD, 8'h00);
      cmd(OP_START, 8'h05);
      check("b0_done", 8'(done), 8'h1);
      check("b0_busy", 8'(busy), 8'h0);
      check("b0_oeb", 8'(io_oeb), 8'h0);
      step();
      check("b0_done_1cyc", 8'(done), 8'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
